// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// segment bit positions, glyph constants and the nibble-to-glyph mapping.
package seg7_pkg;

   // Segment bit positions inside a 7-bit glyph word (a is the MSB).
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   typedef logic [6:0] seg_t;

   // Active-high glyphs, bit6=a ... bit0=g.
   localparam seg_t GLYPH_0     = 7'h7E;
   localparam seg_t GLYPH_1     = 7'h30;
   localparam seg_t GLYPH_2     = 7'h6D;
   localparam seg_t GLYPH_3     = 7'h79;
   localparam seg_t GLYPH_4     = 7'h33;
   localparam seg_t GLYPH_5     = 7'h5B;
   localparam seg_t GLYPH_6     = 7'h5F;
   localparam seg_t GLYPH_7     = 7'h70;
   localparam seg_t GLYPH_8     = 7'h7F;
   localparam seg_t GLYPH_9     = 7'h7B;
   localparam seg_t GLYPH_A     = 7'h77;
   localparam seg_t GLYPH_B     = 7'h1F;
   localparam seg_t GLYPH_C     = 7'h4E;
   localparam seg_t GLYPH_D     = 7'h3D;
   localparam seg_t GLYPH_E     = 7'h4F;
   localparam seg_t GLYPH_F     = 7'h47;
   localparam seg_t GLYPH_BLANK = 7'h00;

   // Map one nibble to its glyph; codes 10-15 are blank unless hex_en is set.
   function automatic seg_t seg7_glyph(input logic [3:0] nibble, input logic hex_en);
      seg_t g;
      case (nibble)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = hex_en ? GLYPH_A : GLYPH_BLANK;
         4'hB:    g = hex_en ? GLYPH_B : GLYPH_BLANK;
         4'hC:    g = hex_en ? GLYPH_C : GLYPH_BLANK;
         4'hD:    g = hex_en ? GLYPH_D : GLYPH_BLANK;
         4'hE:    g = hex_en ? GLYPH_E : GLYPH_BLANK;
         4'hF:    g = hex_en ? GLYPH_F : GLYPH_BLANK;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle of the data-side and pin-side signals of the scan driver.
// The producer of the value (datapath / bench) uses the master view,
// the driver itself uses the slave view.
interface seg7_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic [4*N_DIGITS-1:0] value;
   logic [N_DIGITS-1:0]   dp_in;
   logic                  load;
   logic                  blank_lz;
   logic [6:0]            seg;
   logic                  dp;
   logic [N_DIGITS-1:0]   dig_en;
   logic                  frame_done;

   modport master (
      output value, dp_in, load, blank_lz,
      input  seg, dp, dig_en, frame_done
   );

   modport slave (
      input  value, dp_in, load, blank_lz,
      output seg, dp, dig_en, frame_done
   );
endinterface

// File: rtl/seg7_glyph_dec.sv
// Combinational nibble-to-7-segment decoder. Generalised form of the old
// single-digit BCD decoder; HEX_EN selects whether codes 10-15 show A-F.
module seg7_glyph_dec
   import seg7_pkg::*;
#(
   parameter int HEX_EN = 0
) (
   input  logic [3:0] nibble,
   output seg_t       glyph
);

   localparam logic HEX_SEL = (HEX_EN != 0) ? 1'b1 : 1'b0;

   // Pure table lookup through the shared package function.
   always_comb begin
      glyph = seg7_glyph(nibble, HEX_SEL);
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for N common-electrode 7-segment digits.
// A new value is captured into a pending register on load and promoted to
// the display register only at frame boundaries so a frame never tears.
// Each digit slot starts with a short all-off gap to avoid ghosting.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int BLANK_CYC      = 2,
   parameter int HEX_EN         = 0,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input logic              clk,
   input logic              rst_n,
   seg7_scan_driver_if.slave bus
);

   localparam int P_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int D_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int V_W = 4 * N_DIGITS;

   localparam logic [P_W-1:0] P_LAST = P_W'(SCAN_DIV - 1);
   localparam logic [D_W-1:0] D_LAST = D_W'(N_DIGITS - 1);

   // Polarity masks XORed into the output registers.
   localparam seg_t                SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                DP_INV  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [N_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                                                                  : {N_DIGITS{1'b0}};

   // Scan counters
   logic [P_W-1:0]      p_r;
   logic [D_W-1:0]      d_r;
   logic                slot_end_s;
   logic                frame_tick_s;

   // Capture / display storage
   logic [V_W-1:0]      pend_val_r;
   logic [N_DIGITS-1:0] pend_dp_r;
   logic                pend_r;
   logic [V_W-1:0]      disp_val_r;
   logic [N_DIGITS-1:0] disp_dp_r;

   // Digit selection and glyph path
   logic [3:0]          nibble_s;
   logic                dp_sel_s;
   logic [N_DIGITS-1:0] lz_s;
   logic                lz_sel_s;
   logic                blank_s;
   logic                gap_s;
   seg_t                glyph_s;

   // Next values for the output registers
   seg_t                seg_nx_s;
   logic                dp_nx_s;
   logic [N_DIGITS-1:0] dig_nx_s;

   // Output registers
   seg_t                seg_r;
   logic                dp_r;
   logic [N_DIGITS-1:0] dig_en_r;
   logic                frame_done_r;

   assign slot_end_s   = (p_r == P_LAST);
   assign frame_tick_s = slot_end_s && (d_r == D_LAST);

   // Prescaler counts through a slot; digit index steps at slot end and wraps at frame end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_r <= {P_W{1'b0}};
         d_r <= {D_W{1'b0}};
      end else if (slot_end_s) begin
         p_r <= {P_W{1'b0}};
         if (frame_tick_s) begin
            d_r <= {D_W{1'b0}};
         end else begin
            d_r <= d_r + D_W'(1);
         end
      end else begin
         p_r <= p_r + P_W'(1);
      end
   end

   // Pending register: every load overwrites it, so the last write wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_val_r <= {V_W{1'b0}};
         pend_dp_r  <= {N_DIGITS{1'b0}};
      end else if (bus.load) begin
         pend_val_r <= bus.value;
         pend_dp_r  <= bus.dp_in;
      end else begin
         pend_val_r <= pend_val_r;
         pend_dp_r  <= pend_dp_r;
      end
   end

   // Pending flag: set by load between frames, always cleared at the frame tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_r <= 1'b0;
      end else if (frame_tick_s) begin
         pend_r <= 1'b0;
      end else if (bus.load) begin
         pend_r <= 1'b1;
      end else begin
         pend_r <= pend_r;
      end
   end

   // Display register only moves at the frame tick; a load in that very cycle beats the pending copy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         disp_val_r <= {V_W{1'b0}};
         disp_dp_r  <= {N_DIGITS{1'b0}};
      end else if (frame_tick_s && bus.load) begin
         disp_val_r <= bus.value;
         disp_dp_r  <= bus.dp_in;
      end else if (frame_tick_s && pend_r) begin
         disp_val_r <= pend_val_r;
         disp_dp_r  <= pend_dp_r;
      end else begin
         disp_val_r <= disp_val_r;
         disp_dp_r  <= disp_dp_r;
      end
   end

   // Leading-zero chain: lz_s[k] is set when nibbles N-1 down to k are all zero.
   always_comb begin
      logic run_v;
      lz_s  = {N_DIGITS{1'b0}};
      run_v = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         run_v   = run_v & (disp_val_r[k*4 +: 4] == 4'h0);
         lz_s[k] = run_v;
      end
   end

   // Select the nibble, decimal point and blanking flag of the active digit.
   always_comb begin
      nibble_s = disp_val_r[{d_r, 2'b00} +: 4];
      dp_sel_s = disp_dp_r[d_r];
      lz_sel_s = lz_s[d_r];
   end

   // Digit 0 always shows, even when the whole value is zero.
   assign blank_s = bus.blank_lz && (d_r != {D_W{1'b0}}) && lz_sel_s;

   // All digits dark during the first BLANK_CYC cycles of every slot.
   assign gap_s = (int'(p_r) < BLANK_CYC);

   seg7_glyph_dec #(
      .HEX_EN (HEX_EN)
   ) u_glyph_dec (
      .nibble (nibble_s),
      .glyph  (glyph_s)
   );

   // Build the active-high pin values for the current (p, d) position.
   always_comb begin
      seg_nx_s = GLYPH_BLANK;
      dp_nx_s  = 1'b0;
      dig_nx_s = {N_DIGITS{1'b0}};
      if (gap_s) begin
         seg_nx_s = GLYPH_BLANK;
         dp_nx_s  = 1'b0;
         dig_nx_s = {N_DIGITS{1'b0}};
      end else begin
         seg_nx_s      = blank_s ? GLYPH_BLANK : glyph_s;
         dp_nx_s       = dp_sel_s;
         dig_nx_s[d_r] = 1'b1;
      end
   end

   // Output registers: polarity is applied here, last in the path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_r        <= SEG_INV;
         dp_r         <= DP_INV;
         dig_en_r     <= DIG_INV;
         frame_done_r <= 1'b0;
      end else begin
         seg_r        <= seg_nx_s ^ SEG_INV;
         dp_r         <= dp_nx_s ^ DP_INV;
         dig_en_r     <= dig_nx_s ^ DIG_INV;
         frame_done_r <= frame_tick_s;
      end
   end

   assign bus.seg        = seg_r;
   assign bus.dp         = dp_r;
   assign bus.dig_en     = dig_en_r;
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a table of values with hand-computed
// glyphs per digit, plus hand-written reset, load-override and single-digit
// sequences. Four instances share the clock and reset:
//   dut_a : N=4, SCAN_DIV=8, BLANK_CYC=2, BCD, active-high
//   dut_h : same, HEX_EN=1
//   dut_l : same as dut_a, segments and digit enables active-low
//   dut_1 : N=1, SCAN_DIV=4, BLANK_CYC=1
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] val_t;
   logic [3:0]  dp_t;
   logic        load_t;
   logic        blz_t;
   logic [3:0]  val1_t;
   logic        dp1_t;
   logic        load1_t;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [15:0]     value;
      logic [3:0]      dp;
      logic            blz;
      logic [3:0][6:0] exp_a;
      logic [3:0][6:0] exp_h;
   } vec_t;

   vec_t vecs[8];
   vec_t v_ovr;

   seg7_scan_driver_if #(.N_DIGITS(4)) if_a ();
   seg7_scan_driver_if #(.N_DIGITS(4)) if_h ();
   seg7_scan_driver_if #(.N_DIGITS(4)) if_l ();
   seg7_scan_driver_if #(.N_DIGITS(1)) if_1 ();

   assign if_a.value = val_t;  assign if_a.dp_in = dp_t;  assign if_a.load = load_t;  assign if_a.blank_lz = blz_t;
   assign if_h.value = val_t;  assign if_h.dp_in = dp_t;  assign if_h.load = load_t;  assign if_h.blank_lz = blz_t;
   assign if_l.value = val_t;  assign if_l.dp_in = dp_t;  assign if_l.load = load_t;  assign if_l.blank_lz = blz_t;
   assign if_1.value = val1_t; assign if_1.dp_in = dp1_t; assign if_1.load = load1_t; assign if_1.blank_lz = blz_t;

   seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .HEX_EN(0),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .HEX_EN(1),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
      dut_h (.clk(clk), .rst_n(rst_n), .bus(if_h));
   seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .HEX_EN(0),
                      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
      dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));
   seg7_scan_driver #(.N_DIGITS(1), .SCAN_DIV(4), .BLANK_CYC(1), .HEX_EN(0),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0))
      dut_1 (.clk(clk), .rst_n(rst_n), .bus(if_1));

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runaway guard
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bounded wait for frame_done of the 4-digit instances; checks the current negedge first.
   task automatic wait_fd(input string name);
      int cnt;
      cnt = 0;
      while (if_a.frame_done !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk(name, 32'(if_a.frame_done), 32'h1);
   endtask

   // Called at the negedge where frame_done is high; checks the following 32-cycle frame.
   task automatic check_frame(input vec_t v, input string tag);
      int p;
      int d;
      logic [6:0] inv_seg;
      logic [3:0] onehot;
      logic [3:0] inv_dig;
      logic       inv_dp;
      for (int j = 1; j <= 32; j++) begin
         @(negedge clk);
         p = (j - 1) % 8;
         d = (j - 1) / 8;
         if (p == 0) begin
            chk($sformatf("%s_d%0d_gap_dig_a", tag, d), 32'(if_a.dig_en), 32'h0);
            chk($sformatf("%s_d%0d_gap_seg_a", tag, d), 32'(if_a.seg), 32'h0);
            chk($sformatf("%s_d%0d_gap_dig_l", tag, d), 32'(if_l.dig_en), 32'hF);
            chk($sformatf("%s_d%0d_gap_seg_l", tag, d), 32'(if_l.seg), 32'h7F);
         end
         if (p == 4) begin
            onehot  = 4'b0001 << d;
            inv_dig = ~onehot;
            inv_seg = ~v.exp_a[d];
            inv_dp  = ~v.dp[d];
            chk($sformatf("%s_d%0d_seg_a", tag, d), 32'(if_a.seg), 32'(v.exp_a[d]));
            chk($sformatf("%s_d%0d_dig_a", tag, d), 32'(if_a.dig_en), 32'(onehot));
            chk($sformatf("%s_d%0d_dp_a", tag, d), 32'(if_a.dp), 32'(v.dp[d]));
            chk($sformatf("%s_d%0d_seg_h", tag, d), 32'(if_h.seg), 32'(v.exp_h[d]));
            chk($sformatf("%s_d%0d_seg_l", tag, d), 32'(if_l.seg), 32'(inv_seg));
            chk($sformatf("%s_d%0d_dig_l", tag, d), 32'(if_l.dig_en), 32'(inv_dig));
            chk($sformatf("%s_d%0d_dp_l", tag, d), 32'(if_l.dp), 32'(inv_dp));
         end
         if (j == 16) chk($sformatf("%s_fd_mid", tag), 32'(if_a.frame_done), 32'h0);
         if (j == 32) chk($sformatf("%s_fd_period", tag), 32'(if_a.frame_done), 32'h1);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n   = 1'b0;
      val_t   = 16'h0000;
      dp_t    = 4'h0;
      load_t  = 1'b0;
      blz_t   = 1'b0;
      val1_t  = 4'h0;
      dp1_t   = 1'b0;
      load1_t = 1'b0;

      //            value     dp    blz       d3     d2     d1     d0           hex d3..d0
      vecs[0] = '{value:16'h1234, dp:4'h0, blz:1'b0, exp_a:{7'h30,7'h6D,7'h79,7'h33}, exp_h:{7'h30,7'h6D,7'h79,7'h33}};
      vecs[1] = '{value:16'h0070, dp:4'h0, blz:1'b1, exp_a:{7'h00,7'h00,7'h70,7'h7E}, exp_h:{7'h00,7'h00,7'h70,7'h7E}};
      vecs[2] = '{value:16'h0000, dp:4'h0, blz:1'b1, exp_a:{7'h00,7'h00,7'h00,7'h7E}, exp_h:{7'h00,7'h00,7'h00,7'h7E}};
      vecs[3] = '{value:16'hABCD, dp:4'h0, blz:1'b0, exp_a:{7'h00,7'h00,7'h00,7'h00}, exp_h:{7'h77,7'h1F,7'h4E,7'h3D}};
      vecs[4] = '{value:16'h0F00, dp:4'h0, blz:1'b1, exp_a:{7'h00,7'h00,7'h7E,7'h7E}, exp_h:{7'h00,7'h47,7'h7E,7'h7E}};
      vecs[5] = '{value:16'h0005, dp:4'hA, blz:1'b1, exp_a:{7'h00,7'h00,7'h00,7'h5B}, exp_h:{7'h00,7'h00,7'h00,7'h5B}};
      vecs[6] = '{value:16'h0070, dp:4'h5, blz:1'b0, exp_a:{7'h7E,7'h7E,7'h70,7'h7E}, exp_h:{7'h7E,7'h7E,7'h70,7'h7E}};
      vecs[7] = '{value:16'h9876, dp:4'h0, blz:1'b1, exp_a:{7'h7B,7'h7F,7'h70,7'h5F}, exp_h:{7'h7B,7'h7F,7'h70,7'h5F}};
      v_ovr   = '{value:16'h2222, dp:4'h0, blz:1'b1, exp_a:{7'h6D,7'h6D,7'h6D,7'h6D}, exp_h:{7'h6D,7'h6D,7'h6D,7'h6D}};

      // ---- Reset, then re-assert reset in the middle of a scan ----
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (13) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_seg_a", 32'(if_a.seg), 32'h0);
      chk("rst_dig_a", 32'(if_a.dig_en), 32'h0);
      chk("rst_dp_a",  32'(if_a.dp), 32'h0);
      chk("rst_fd_a",  32'(if_a.frame_done), 32'h0);
      chk("rst_seg_l", 32'(if_l.seg), 32'h7F);
      chk("rst_dig_l", 32'(if_l.dig_en), 32'hF);
      chk("rst_dp_l",  32'(if_l.dp), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("post_rst%0d_seg_a", c), 32'(if_a.seg), 32'h0);
         chk($sformatf("post_rst%0d_dig_a", c), 32'(if_a.dig_en), 32'h0);
         chk($sformatf("post_rst%0d_fd_a", c),  32'(if_a.frame_done), 32'h0);
         @(negedge clk);
      end
      chk("post_rst_show_seg_a", 32'(if_a.seg), 32'h7E);
      chk("post_rst_show_dig_a", 32'(if_a.dig_en), 32'h1);
      chk("post_rst_show_seg_l", 32'(if_l.seg), 32'h01);
      chk("post_rst_show_dig_l", 32'(if_l.dig_en), 32'hE);

      // ---- Table-driven frames ----
      for (int i = 0; i < 8; i++) begin
         val_t  = vecs[i].value;
         dp_t   = vecs[i].dp;
         blz_t  = vecs[i].blz;
         load_t = 1'b1;
         @(negedge clk);
         load_t = 1'b0;
         wait_fd($sformatf("v%0d_fd_wait", i));
         check_frame(vecs[i], $sformatf("v%0d", i));
      end

      // ---- Mid-frame load is invisible; a load on the frame tick overrides it ----
      // Now at cycle 0 of a frame showing 9876.
      repeat (10) @(negedge clk);
      val_t  = 16'h1111;
      load_t = 1'b1;
      @(negedge clk);
      load_t = 1'b0;
      repeat (9) @(negedge clk);
      chk("ovr_cur_frame_seg", 32'(if_a.seg), 32'h7F);
      chk("ovr_cur_frame_dig", 32'(if_a.dig_en), 32'h4);
      repeat (11) @(negedge clk);
      val_t  = 16'h2222;
      load_t = 1'b1;
      @(negedge clk);
      load_t = 1'b0;
      chk("ovr_fd_at_tick", 32'(if_a.frame_done), 32'h1);
      check_frame(v_ovr, "ovr1");
      check_frame(v_ovr, "ovr2");

      // ---- Single-digit instance: every slot is a frame ----
      val1_t  = 4'h9;
      dp1_t   = 1'b1;
      load1_t = 1'b1;
      @(negedge clk);
      load1_t = 1'b0;
      begin
         int cnt;
         cnt = 0;
         while (if_1.frame_done !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
         end
      end
      chk("u1_fd_seen", 32'(if_1.frame_done), 32'h1);
      @(negedge clk);
      chk("u1_gap_dig", 32'(if_1.dig_en), 32'h0);
      chk("u1_gap_seg", 32'(if_1.seg), 32'h0);
      @(negedge clk);
      chk("u1_seg", 32'(if_1.seg), 32'h7B);
      chk("u1_dig", 32'(if_1.dig_en), 32'h1);
      chk("u1_dp",  32'(if_1.dp), 32'h1);
      @(negedge clk);
      chk("u1_fd_low", 32'(if_1.frame_done), 32'h0);
      @(negedge clk);
      chk("u1_fd_period", 32'(if_1.frame_done), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
